// File: rtl/two_way_pkg.sv
// rtl/two_way_pkg.sv - shared state type and default width for the Gray step decoder
package two_way_pkg;

    localparam int TW_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } two_way_state_t;

endpackage

// File: rtl/gray2bin_g.sv
// rtl/gray2bin_g.sv - combinational Gray-to-binary decode
module gray2bin_g #(
    parameter int W = 3
) (
    input  logic [W-1:0] g,
    output logic [W-1:0] b
);

    assign b[W-1] = g[W-1];

    // Each binary bit folds in every more-significant Gray bit.
    for (genvar i = 0; i < W - 1; i++) begin : g_fold
        assign b[i] = b[i+1] ^ g[i];
    end

endmodule

// File: rtl/two_way_decode_g.sv
// rtl/two_way_decode_g.sv - Gray up/down counter sample tracker with direction, wrap and error flags
module two_way_decode_g
    import two_way_pkg::*;
#(
    parameter int W = TW_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] g,
    input  logic         en,
    input  logic         clr,
    output logic         x,
    output logic         l,
    output logic         valid,
    output logic         err,
    output logic [W-1:0] bin
);

    localparam logic [W-1:0] STEP_UP   = W'(1);
    localparam logic [W-1:0] STEP_DOWN = '1;
    localparam logic [W-1:0] ZERO      = '0;

    two_way_state_t state;
    logic [W-1:0]   g_bin;
    logic [W-1:0]   d;

    gray2bin_g #(.W(W)) u_decode (
        .g (g),
        .b (g_bin)
    );

    // Modulo-2^W distance from the last accepted value.
    assign d = g_bin - bin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            x     <= 1'b0;
            l     <= 1'b0;
            valid <= 1'b0;
            err   <= 1'b0;
            bin   <= '0;
        end else begin
            valid <= 1'b0;
            l     <= 1'b0;
            if (clr) begin
                state <= EMPTY;
                err   <= 1'b0;
                bin   <= '0;
            end else if (en) begin
                case (state)
                    EMPTY: begin
                        bin   <= g_bin;
                        state <= TRACK;
                    end
                    TRACK: begin
                        if (d == STEP_UP) begin
                            x     <= 1'b1;
                            valid <= 1'b1;
                            l     <= (bin == STEP_DOWN);
                            bin   <= g_bin;
                        end else if (d == STEP_DOWN) begin
                            x     <= 1'b0;
                            valid <= 1'b1;
                            l     <= (bin == ZERO);
                            bin   <= g_bin;
                        end else if (d != ZERO) begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end
                    end
                    ERROR: begin
                        err <= 1'b1;
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_two_way_decode_g.sv
// tb/tb_two_way_decode_g.sv - scoreboard bench for two_way_decode_g with directed Gray vectors
module tb_two_way_decode_g;

    logic       clk;
    logic       reset;
    logic [2:0] g;
    logic       en;
    logic       clr;
    logic       x;
    logic       l;
    logic       valid;
    logic       err;
    logic [2:0] bin;

    typedef struct {
        logic       x;
        logic       l;
        logic       v;
        logic       e;
        logic [2:0] b;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rec      = 0;

    two_way_decode_g #(.W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .g     (g),
        .en    (en),
        .clr   (clr),
        .x     (x),
        .l     (l),
        .valid (valid),
        .err   (err),
        .bin   (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: one expected record per clocked step, compared away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                rec++;
                chk($sformatf("step%0d.x", rec), 32'(x), 32'(e.x));
                chk($sformatf("step%0d.l", rec), 32'(l), 32'(e.l));
                chk($sformatf("step%0d.valid", rec), 32'(valid), 32'(e.v));
                chk($sformatf("step%0d.err", rec), 32'(err), 32'(e.e));
                chk($sformatf("step%0d.bin", rec), 32'(bin), 32'(e.b));
            end
        end
    end

    task automatic step(input logic se, input logic [2:0] sg, input logic sc,
                        input logic ex, input logic el, input logic ev,
                        input logic ee, input logic [2:0] eb);
        exp_t e;
        en  = se;
        g   = sg;
        clr = sc;
        @(posedge clk);
        e.x = ex; e.l = el; e.v = ev; e.e = ee; e.b = eb;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".x"}, 32'(x), 0);
        chk({nm, ".l"}, 32'(l), 0);
        chk({nm, ".valid"}, 32'(valid), 0);
        chk({nm, ".err"}, 32'(err), 0);
        chk({nm, ".bin"}, 32'(bin), 0);
    endtask

    initial begin
        int guard;
        reset = 1'b0;
        en    = 1'b1;
        g     = 3'b011;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;

        //   en  g       clr   x  l  v  e  bin
        step(1, 3'b000, 0,    0, 0, 0, 0, 3'd0);   // reference sample
        step(1, 3'b001, 0,    1, 0, 1, 0, 3'd1);
        step(1, 3'b011, 0,    1, 0, 1, 0, 3'd2);
        step(1, 3'b010, 0,    1, 0, 1, 0, 3'd3);
        step(1, 3'b110, 0,    1, 0, 1, 0, 3'd4);
        step(1, 3'b111, 0,    1, 0, 1, 0, 3'd5);
        step(1, 3'b101, 0,    1, 0, 1, 0, 3'd6);
        step(1, 3'b100, 0,    1, 0, 1, 0, 3'd7);
        step(1, 3'b000, 0,    1, 1, 1, 0, 3'd0);   // up wrap
        step(1, 3'b100, 0,    0, 1, 1, 0, 3'd7);   // down wrap
        step(1, 3'b101, 0,    0, 0, 1, 0, 3'd6);
        step(0, 3'b010, 0,    0, 0, 0, 0, 3'd6);   // en low holds
        step(1, 3'b100, 0,    1, 0, 1, 0, 3'd7);
        step(1, 3'b000, 0,    1, 1, 1, 0, 3'd0);
        step(1, 3'b001, 0,    1, 0, 1, 0, 3'd1);
        step(1, 3'b010, 0,    1, 0, 0, 1, 3'd1);   // d=2 illegal
        step(1, 3'b011, 0,    1, 0, 0, 1, 3'd1);   // sticky in ERROR
        step(0, 3'b110, 0,    1, 0, 0, 1, 3'd1);
        step(1, 3'b000, 1,    1, 0, 0, 0, 3'd0);   // clr beats en, x holds
        step(1, 3'b011, 0,    1, 0, 0, 0, 3'd2);   // new reference
        step(1, 3'b011, 0,    1, 0, 0, 0, 3'd2);   // stall
        step(0, 3'b101, 0,    1, 0, 0, 0, 3'd2);
        step(0, 3'b110, 0,    1, 0, 0, 0, 3'd2);
        step(1, 3'b010, 0,    1, 0, 1, 0, 3'd3);
        step(1, 3'b011, 0,    0, 0, 1, 0, 3'd2);   // down step
        step(1, 3'b010, 0,    1, 0, 1, 0, 3'd3);
        step(1, 3'b110, 0,    1, 0, 1, 0, 3'd4);
        step(1, 3'b111, 0,    1, 0, 1, 0, 3'd5);

        #2 reset = 1'b0;
        #1 chk_zero("midreset");
        en = 1'b1;
        g  = 3'b001;
        @(negedge clk);
        chk_zero("heldreset");
        reset = 1'b1;

        step(1, 3'b110, 0,    0, 0, 0, 0, 3'd4);   // reference after reset
        step(1, 3'b111, 0,    1, 0, 1, 0, 3'd5);
        step(0, 3'b000, 0,    1, 0, 0, 0, 3'd5);

        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("queue_drained", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/two_way_decode_g.md
TWO_WAY_DECODE_G -- requirements
Module: two_way_decode_g

Interface
REQ-001 Parameter: W, default 3, width of the Gray-coded count word and of the decoded binary value (W >= 2).
REQ-002 Port: clk  input  1  rising-edge clock, the only clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: g  input  W  Gray-coded count sample from the up/down counter.
REQ-005 Port: en  input  1  sample strobe; g is evaluated only when en=1.
REQ-006 Port: clr  input  1  synchronous clear of error and tracking state.
REQ-007 Port: x  output  1  decoded direction of the last legal step (1 = up, 0 = down).
REQ-008 Port: l  output  1  one-cycle pulse on a wrap step (max->0 up, or 0->max down).
REQ-009 Port: valid  output  1  one-cycle pulse when a legal single step is decoded.
REQ-010 Port: err  output  1  sticky illegal-step flag.
REQ-011 Port: bin  output  W  binary value of the last accepted sample.

Function
REQ-012 Gray-to-binary rule: bin[W-1] = g[W-1]; bin[i] = bin[i+1] XOR g[i] for i < W-1.
REQ-013 All outputs SHALL be registered, with 1-cycle latency from the en-qualified sample to x, l, valid, err and bin.
REQ-014 FSM states: EMPTY (no reference sample), TRACK, ERROR.
REQ-015 EMPTY with en=1: load bin <= decode(g); valid=0; go to TRACK.
REQ-016 TRACK with en=1: compute d = decode(g) - bin, modulo 2^W.
REQ-017 d == 1: x<=1, valid pulse, bin updates; l pulses if the old bin was 2^W-1.
REQ-018 d == 2^W-1: x<=0, valid pulse, bin updates; l pulses if the old bin was 0.
REQ-019 d == 0: stall; no pulse, no error, all registers hold.
REQ-020 Any other d: err<=1, valid=0, l=0, bin holds; go to ERROR.
REQ-021 ERROR: ignore en; err stays 1; valid=0 and l=0.
REQ-022 clr=1 in any state: next state EMPTY, err<=0, bin<=0, x holds; clr takes priority over en in the same cycle.
REQ-023 en=0 without clr: state and all registers hold; valid=0 and l=0.
REQ-024 valid and l SHALL never be high for more than one consecutive cycle without a new en-qualified legal step.
REQ-025 l SHALL be high only in a cycle where valid is also high.

Reset
REQ-026 reset=0 SHALL immediately force: state EMPTY, x=0, l=0, valid=0, err=0, bin=0.
REQ-027 If reset is asserted mid-operation, including while in ERROR, the block SHALL discard the prior sample, and the first en after release SHALL be treated as a reference sample only.
REQ-028 Reset release SHALL be synchronised by the integrator; the block SHALL NOT add a synchroniser.

Structure
REQ-029 Shared package two_way_pkg SHALL hold the FSM state type (EMPTY/TRACK/ERROR) and the default width constant TW_W=3.
REQ-030 Gray-to-binary decode SHALL be one combinational sub-module, gray2bin_g, parameterised by W.
REQ-031 The FSM, the modulo subtractor and the output registers SHALL live in two_way_decode_g.

Verification (W=3; Gray sequence 000,001,011,010,110,111,101,100 = binary 0..7)
REQ-032 reset=0 at t=0, then release -> all outputs 0, state EMPTY; the first en with g=000 gives valid=0.
REQ-033 Up sweep with en=1 per cycle, 000->001->...->100->000 -> valid=1 and x=1 on each step, bin=1..7 then 0, and l=1 only on the 100->000 step.
REQ-034 Down step from bin=0, g=000->100 -> x=0, valid=1, l=1, bin=7; then 100->101 -> x=0, l=0, bin=6.
REQ-035 Illegal jump in TRACK at bin=1, g=001->010 (d=2) -> err=1 next cycle and stays 1 through further en; valid=0; bin holds 1; clr=1 together with en=1 -> err=0 and state EMPTY.
REQ-036 Repeated g with en=1 (011,011) -> no valid, no err; en=0 while g changes arbitrarily -> no output change.
REQ-037 reset pulsed low mid-sweep at bin=5 -> outputs clear at once; after release, g=110 is taken as the reference (valid=0), then g=111 -> valid=1, x=1, bin=5.
